// File: rtl/cache_ctrl.sv
// cache_ctrl: single-port cache controller, write-through with no-write-allocate, full-line refill on read miss.
// Latency: read hit responds 2 cycles after grant, read miss 1 cycle after the last refill ack, write 1 cycle after memory ack.
// Backpressure: one request in flight; grant only while idle, and memory requests are held until mem_ack_i.
module cache_ctrl #(
  parameter int WIDTH = 32,
  parameter int C     = 16,
  parameter int WORDS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_req_i,
  input  logic             cpu_we_i,
  input  logic [WIDTH-1:0] cpu_addr_i,
  input  logic [WIDTH-1:0] cpu_wdata_i,
  output logic             cpu_gnt_o,
  output logic             cpu_resp_o,
  output logic [WIDTH-1:0] cpu_rdata_o,
  output logic             cache_wen_o,
  output logic [WIDTH-1:0] cache_addr_o,
  output logic [WIDTH-1:0] cache_data_o,
  input  logic             cache_hit_i,
  input  logic [WIDTH-1:0] cache_data_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0] mem_wdata_o,
  input  logic             mem_ack_i,
  input  logic [WIDTH-1:0] mem_rdata_i,
  output logic [15:0]      hit_cnt_o,
  output logic [15:0]      miss_cnt_o
);

  // Byte-offset bits within a line, and the refill word counter width.
  localparam int OFF_W = $clog2(WORDS) + 2;
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS - 1);
  localparam logic [WIDTH-1:0] OFF_MASK = WIDTH'((1 << OFF_W) - 1);
  localparam logic [15:0]      CNT_MAX  = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    REFILL,
    WR_MEM,
    RESP
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] addr_q;
  logic             we_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] rdata_q;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      hit_cnt_q;
  logic [15:0]      miss_cnt_q;
  logic [CNT_W-1:0] req_off;
  logic [WIDTH-1:0] refill_addr;

  // Word offset of the requested word inside its line; a one-word line has no offset field.
  if (WORDS > 1) begin : g_off
    assign req_off = addr_q[OFF_W-1:2];
  end else begin : g_off_one
    assign req_off = '0;
  end

  // Refill walks the line from its base upward, one word per ack.
  assign refill_addr = (addr_q & ~OFF_MASK) | (WIDTH'(cnt_q) << 2);

  assign cpu_rdata_o = rdata_q;
  assign hit_cnt_o   = hit_cnt_q;
  assign miss_cnt_o  = miss_cnt_q;

  // State register; reset drops any in-flight memory request immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and all interface strobes; everything idles low unless a state drives it.
  always_comb begin
    state_d      = state_q;
    cpu_gnt_o    = 1'b0;
    cpu_resp_o   = 1'b0;
    cache_wen_o  = 1'b0;
    cache_addr_o = addr_q;
    cache_data_o = '0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    case (state_q)
      IDLE: begin
        // Gated by rst_n so the grant is also low while reset is held.
        cpu_gnt_o = rst_n;
        if (cpu_req_i) begin
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (we_q) begin
          // Write-through: update the array only on a hit, never allocate.
          if (cache_hit_i) begin
            cache_wen_o  = 1'b1;
            cache_data_o = wdata_q;
          end
          state_d = WR_MEM;
        end else if (cache_hit_i) begin
          state_d = RESP;
        end else begin
          state_d = REFILL;
        end
      end
      REFILL: begin
        mem_req_o  = 1'b1;
        mem_addr_o = refill_addr;
        if (mem_ack_i) begin
          cache_wen_o  = 1'b1;
          cache_addr_o = refill_addr;
          cache_data_o = mem_rdata_i;
          if (cnt_q == CNT_LAST) begin
            state_d = RESP;
          end
        end
      end
      WR_MEM: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        if (mem_ack_i) begin
          state_d = RESP;
        end
      end
      RESP: begin
        cpu_resp_o = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request latches, read-data capture and refill word counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cpu_req_i) begin
            addr_q  <= cpu_addr_i;
            we_q    <= cpu_we_i;
            wdata_q <= cpu_wdata_i;
          end
        end
        LOOKUP: begin
          if (!we_q) begin
            if (cache_hit_i) begin
              rdata_q <= cache_data_i;
            end else begin
              cnt_q <= '0;
            end
          end
        end
        REFILL: begin
          if (mem_ack_i) begin
            // The word the CPU asked for may arrive anywhere in the line walk.
            if (cnt_q == req_off) begin
              rdata_q <= mem_rdata_i;
            end
            cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Hit/miss statistics, counted once per lookup and pinned at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == LOOKUP) begin
      if (cache_hit_i) begin
        if (hit_cnt_q != CNT_MAX) begin
          hit_cnt_q <= hit_cnt_q + 16'd1;
        end
      end else if (miss_cnt_q != CNT_MAX) begin
        miss_cnt_q <= miss_cnt_q + 16'd1;
      end
    end
  end

endmodule
